// File: rtl/multi_glide_if.sv
// Configuration-write and status bundle for the multi-channel glide engine.
// The master side drives writes and sample ticks; the slave side is the engine.
interface multi_glide_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      tick;
    logic                      wr_en;
    logic [CH_W-1:0]           wr_ch;
    logic [WIDTH-1:0]          wr_target;
    logic [WIDTH-1:0]          wr_rate;
    logic                      wr_mode;
    logic                      wr_snap;
    logic [CHANNELS*WIDTH-1:0] out;
    logic [CHANNELS-1:0]       settled;
    logic                      busy;
    logic                      overrun;

    modport master (
        output tick, wr_en, wr_ch, wr_target, wr_rate, wr_mode, wr_snap,
        input  out, settled, busy, overrun
    );

    modport slave (
        input  tick, wr_en, wr_ch, wr_target, wr_rate, wr_mode, wr_snap,
        output out, settled, busy, overrun
    );
endinterface

// File: rtl/multi_glide.sv
// Multi-channel portamento engine: one shared datapath slews each channel's
// frequency word toward its target, one channel per cycle after each sample tick.
module multi_glide #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    multi_glide_if.slave  bus
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned DW   = WIDTH + 1;

    typedef enum logic [0:0] {S_IDLE, S_SWEEP} state_t;

    state_t          r_state, w_state_nxt;
    logic [CH_W-1:0] r_ch, w_ch_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_overrun, w_overrun_nxt;
    logic            w_upd;

    logic [WIDTH-1:0] r_cur    [CHANNELS];
    logic [WIDTH-1:0] r_target [CHANNELS];
    logic [WIDTH-1:0] r_rate   [CHANNELS];
    logic             r_mode   [CHANNELS];

    logic [WIDTH-1:0] w_cur, w_tgt, w_rate, w_next;
    logic             w_mode;
    logic [DW-1:0]    w_d, w_shift, w_step, w_sum;

    // Sweep sequencer state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_ch      <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ch      <= w_ch_nxt;
            r_busy    <= w_busy_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    // Sweep sequencer next-state: walk channels ascending, flag ticks that land mid-sweep
    always_comb begin
        w_state_nxt   = r_state;
        w_ch_nxt      = r_ch;
        w_overrun_nxt = r_overrun;
        w_upd         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.tick) begin
                    w_state_nxt = S_SWEEP;
                    w_ch_nxt    = '0;
                end
            end
            S_SWEEP: begin
                w_upd = 1'b1;
                if (bus.tick) begin
                    w_overrun_nxt = 1'b1;
                end
                if (r_ch == CH_W'(CHANNELS - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_ch_nxt    = '0;
                end else begin
                    w_ch_nxt = r_ch + CH_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ch_nxt    = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_SWEEP);
    end

    // Shared step datapath; one bit of headroom so the clamp never wraps
    always_comb begin
        w_cur   = r_cur[r_ch];
        w_tgt   = r_target[r_ch];
        w_rate  = r_rate[r_ch];
        w_mode  = r_mode[r_ch];
        w_d     = (w_cur > w_tgt) ? (DW'(w_cur) - DW'(w_tgt)) : (DW'(w_tgt) - DW'(w_cur));
        w_shift = w_d >> w_rate[3:0];
        if (w_mode) begin
            w_step = ((w_shift == '0) && (w_d != '0)) ? DW'(1) : w_shift;
        end else begin
            w_step = DW'(w_rate);
        end
        w_sum  = DW'(w_cur) + w_step;
        w_next = w_cur;
        if (w_cur < w_tgt) begin
            w_next = (w_sum >= DW'(w_tgt)) ? w_tgt : w_sum[WIDTH-1:0];
        end else if (w_cur > w_tgt) begin
            w_next = (w_step >= w_d) ? w_tgt : (w_cur - w_step[WIDTH-1:0]);
        end
    end

    // Channel registers; a snap write is ordered last so it overrides the sweep result
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_cur[k]    <= '0;
                r_target[k] <= '0;
                r_rate[k]   <= '0;
                r_mode[k]   <= 1'b0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (w_upd && (r_ch == CH_W'(k))) begin
                    r_cur[k] <= w_next;
                end
                if (bus.wr_en && (bus.wr_ch == CH_W'(k))) begin
                    r_target[k] <= bus.wr_target;
                    r_rate[k]   <= bus.wr_rate;
                    r_mode[k]   <= bus.wr_mode;
                    if (bus.wr_snap) begin
                        r_cur[k] <= bus.wr_target;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign bus.out[g*WIDTH +: WIDTH] = r_cur[g];
        assign bus.settled[g]            = (r_cur[g] == r_target[g]);
    end

    assign bus.busy    = r_busy;
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_multi_glide.sv
// Directed bench for multi_glide: expected channel states are queued per sweep
// and a monitor compares them when busy falls at the end of each sweep.
module tb_multi_glide;
    localparam int unsigned WIDTH    = 16;
    localparam int unsigned CHANNELS = 4;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    multi_glide_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    multi_glide #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [63:0] out;
        logic [3:0]  settled;
        logic        overrun;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    logic        prev_busy = 1'b0;
    logic        rst_edge  = 1'b0;
    logic [15:0] lin_v [4] = '{16'd300, 16'd600, 16'd900, 16'd1000};
    logic [15:0] exp_v [3] = '{16'h6000, 16'h4800, 16'h3600};
    logic [15:0] x, s, v;
    int          guard;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_val);
        n_checks++;
        if (act !== exp_val) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_val);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] c0, input logic [15:0] c1,
                                          input logic [15:0] c2, input logic [15:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic push(input string name, input logic [63:0] o, input logic [3:0] st,
                        input logic ov);
        exp_t e;
        e.name    = name;
        e.out     = o;
        e.settled = st;
        e.overrun = ov;
        sb_q.push_back(e);
    endtask

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int ch, input logic [15:0] tgt, input logic [15:0] rate,
                      input logic mode, input logic snap);
        bus.wr_en     = 1'b1;
        bus.wr_ch     = 2'(ch);
        bus.wr_target = tgt;
        bus.wr_rate   = rate;
        bus.wr_mode   = mode;
        bus.wr_snap   = snap;
        sync();
        bus.wr_en   = 1'b0;
        bus.wr_snap = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 20) begin
            sync();
            n++;
        end
        if (bus.busy !== 1'b0) begin
            n_checks++;
            n_errors++;
            $display("FAIL busy_timeout: busy still 0x%0h after %0d cycles, expected 0x0", bus.busy, n);
        end
    endtask

    task automatic tick_once();
        bus.tick = 1'b1;
        sync();
        bus.tick = 1'b0;
        wait_idle();
    endtask

    // Scoreboard monitor: a sweep is complete when busy falls without a reset
    always @(posedge CLK) rst_edge <= RESET;

    always @(negedge CLK) begin
        if (prev_busy === 1'b1 && bus.busy === 1'b0 && !rst_edge) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sweep_end: sweep completed with out 0x%0h but no expected entry", bus.out);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "_out"},     bus.out,               mon_e.out);
                chk({mon_e.name, "_settled"}, 64'(bus.settled),      64'(mon_e.settled));
                chk({mon_e.name, "_overrun"}, 64'(bus.overrun),      64'(mon_e.overrun));
            end
        end
        prev_busy = bus.busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET         = 1'b1;
        bus.tick      = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_ch     = '0;
        bus.wr_target = '0;
        bus.wr_rate   = '0;
        bus.wr_mode   = 1'b0;
        bus.wr_snap   = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;

        @(negedge CLK);
        chk("rst_out",     bus.out,               64'h0);
        chk("rst_settled", 64'(bus.settled),      64'hF);
        chk("rst_busy",    64'(bus.busy),         64'h0);
        chk("rst_overrun", 64'(bus.overrun),      64'h0);
        sync();

        // Idle ticks with every channel already at target
        for (int i = 0; i < 10; i++) begin
            push("idle", 64'h0, 4'hF, 1'b0);
            tick_once();
        end

        // Channel 0 linear glide 0 -> 1000 by 300
        wr(0, 16'd1000, 16'd300, 1'b0, 1'b0);
        chk("wr_settled", 64'(bus.settled), 64'hE);
        for (int i = 0; i < 4; i++) begin
            v = lin_v[i];
            push("lin_ch0", pack4(v, 16'd0, 16'd0, 16'd0), (v == 16'd1000) ? 4'hF : 4'hE, 1'b0);
            tick_once();
        end

        // Channel 1 exponential decay from 0x8000 to 0, shift 2
        wr(1, 16'h8000, 16'd2, 1'b1, 1'b1);
        chk("snap_ch1", bus.out, pack4(16'd1000, 16'h8000, 16'd0, 16'd0));
        wr(1, 16'h0000, 16'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push("exp_ch1", pack4(16'd1000, exp_v[i], 16'd0, 16'd0), 4'hD, 1'b0);
            tick_once();
        end
        x     = 16'h3600;
        guard = 0;
        while (x != 16'd0 && guard < 100) begin
            s = x >> 2;
            if (s == 16'd0) s = 16'd1;
            x = (s >= x) ? 16'd0 : (x - s);
            push("exp_tail", pack4(16'd1000, x, 16'd0, 16'd0), {2'b11, (x == 16'd0), 1'b1}, 1'b0);
            tick_once();
            guard++;
        end

        // Channel 2 clamps at the top of range, then glides down and clamps at 5
        wr(2, 16'hFFF0, 16'd0, 1'b0, 1'b1);
        wr(2, 16'hFFFF, 16'h0100, 1'b0, 1'b0);
        chk("wr_settled_ch2", 64'(bus.settled), 64'hB);
        push("top_clamp", pack4(16'd1000, 16'd0, 16'hFFFF, 16'd0), 4'hF, 1'b0);
        tick_once();
        wr(2, 16'h0005, 16'h1000, 1'b0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            v = 16'hFFFF - 16'(i * 4096);
            push("down_ch2", pack4(16'd1000, 16'd0, v, 16'd0), 4'hB, 1'b0);
            tick_once();
        end
        push("low_clamp", pack4(16'd1000, 16'd0, 16'h0005, 16'd0), 4'hF, 1'b0);
        tick_once();

        // Linear rate 0 holds and stays unsettled
        wr(3, 16'd100, 16'd0, 1'b0, 1'b0);
        push("rate0", pack4(16'd1000, 16'd0, 16'h0005, 16'd0), 4'h7, 1'b0);
        tick_once();

        // Second tick two cycles into a sweep is dropped and flags overrun
        wr(0, 16'd0, 16'd400, 1'b0, 1'b0);
        push("ovr", pack4(16'd600, 16'd0, 16'h0005, 16'd0), 4'h6, 1'b1);
        bus.tick = 1'b1;
        sync();
        bus.tick = 1'b0;
        chk("busy_t1",    64'(bus.busy),     64'h1);
        chk("ch0_before", 64'(bus.out[15:0]), 64'd1000);
        sync();
        chk("ch0_after",  64'(bus.out[15:0]), 64'd600);
        chk("busy_t2",    64'(bus.busy),     64'h1);
        chk("ovr_pre",    64'(bus.overrun),  64'h0);
        bus.tick = 1'b1;
        sync();
        bus.tick = 1'b0;
        chk("ovr_set",    64'(bus.overrun),  64'h1);
        chk("busy_t3",    64'(bus.busy),     64'h1);
        chk("ch0_once",   64'(bus.out[15:0]), 64'd600);
        sync();
        chk("busy_t4",    64'(bus.busy),     64'h1);
        sync();
        chk("busy_drop",  64'(bus.busy),     64'h0);
        push("ovr_sticky", pack4(16'd200, 16'd0, 16'h0005, 16'd0), 4'h6, 1'b1);
        tick_once();

        // Snap to channel 3 on the same edge the sweep updates channel 3
        push("snap_race", pack4(16'd0, 16'd0, 16'h0005, 16'd500), 4'hF, 1'b1);
        bus.tick = 1'b1;
        sync();
        bus.tick = 1'b0;
        sync();
        sync();
        sync();
        wr(3, 16'd500, 16'd0, 1'b0, 1'b1);
        chk("snap_ch3", 64'(bus.out[63:48]), 64'd500);
        wait_idle();

        // Reset in the middle of a sweep
        wr(1, 16'h1234, 16'd16, 1'b0, 1'b1);
        bus.tick = 1'b1;
        sync();
        bus.tick = 1'b0;
        sync();
        RESET = 1'b1;
        sync();
        chk("mid_rst_busy",    64'(bus.busy),    64'h0);
        chk("mid_rst_out",     bus.out,          64'h0);
        chk("mid_rst_overrun", 64'(bus.overrun), 64'h0);
        chk("mid_rst_settled", 64'(bus.settled), 64'hF);
        RESET = 1'b0;
        sync();
        push("post_rst", 64'h0, 4'hF, 1'b0);
        tick_once();

        repeat (3) sync();
        chk("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
